// File: rtl/orion_types.sv
`default_nettype none
// ============================================================================
// Module      : orion_types
// Description : Shared widths and types for the orion core memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package orion_types;

  localparam int ADDRW = 32;
  localparam int DATAW = 32;
  localparam int MASKW = DATAW / 8;

  // Arbiter state: idle, or one transaction outstanding for fetch or data.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Latched downstream request.
  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic             we;
    logic [MASKW-1:0] wmask;
    logic [DATAW-1:0] wdata;
  } arb_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational two-way picker. valid[0] = imem, valid[1] = dmem.
//               Build option ORION_ARB_ROUND_ROBIN_EN selects round-robin tie
//               breaking; otherwise dmem wins every tie.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ORION_ARB_ROUND_ROBIN_EN
  // Tie goes to the port that did not win last time.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11)
      grant = last_grant ? 2'b01 : 2'b10;
    else
      grant = valid;
  end
`else
  // Last grant is tracked by the parent but plays no part in fixed priority.
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  // Fixed priority: dmem beats imem on a tie.
  always_comb begin
    grant = 2'b00;
    if (valid[1])
      grant = 2'b10;
    else if (valid[0])
      grant = 2'b01;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between the fetch and data ports
//               of the orion core. One transaction at a time; the response is
//               routed back to the owner combinationally. Fetch responses can
//               be discarded after a jump (kill).
//               Build option: ORION_ARB_ROUND_ROBIN_EN (round-robin ties).
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import orion_types::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] imem_addr_i,
  input  logic             imem_valid_i,
  input  logic             imem_kill_i,
  output logic [DATAW-1:0] imem_rdata_o,
  output logic             imem_resp_o,
  input  logic [ADDRW-1:0] dmem_addr_i,
  input  logic             dmem_valid_i,
  input  logic             dmem_we_i,
  input  logic [MASKW-1:0] dmem_wmask_i,
  input  logic [DATAW-1:0] dmem_wdata_i,
  output logic [DATAW-1:0] dmem_rdata_o,
  output logic             dmem_resp_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic             mem_valid_o,
  output logic             mem_we_o,
  output logic [MASKW-1:0] mem_wmask_o,
  output logic [DATAW-1:0] mem_wdata_o,
  input  logic [DATAW-1:0] mem_rdata_i,
  input  logic             mem_resp_i
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  arb_req_t   r_req;
  arb_req_t   w_req_next;
  logic       r_discard;
  logic       r_last_grant;
  logic [1:0] w_valid;
  logic [1:0] w_grant;
  logic       w_idle;

  assign w_idle = (r_state == IDLE);

  // A fetch that is being killed in the same cycle is never granted.
  assign w_valid = {dmem_valid_i, imem_valid_i & ~imem_kill_i};

  mem_arb_pick u_pick (
    .valid      (w_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // Next-state and request-capture logic.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    case (r_state)
      IDLE: begin
        if (w_grant[1]) begin
          w_state_next     = BUSY_D;
          w_req_next.addr  = dmem_addr_i;
          w_req_next.we    = dmem_we_i;
          w_req_next.wmask = dmem_wmask_i;
          w_req_next.wdata = dmem_wdata_i;
        end else if (w_grant[0]) begin
          w_state_next     = BUSY_I;
          w_req_next.addr  = imem_addr_i;
          w_req_next.we    = 1'b0;
          w_req_next.wmask = '0;
          w_req_next.wdata = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp_i)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
    end
  end

  // Remember the last winner; 0 = imem, 1 = dmem.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_last_grant <= 1'b0;
    else if (w_idle && (w_grant != 2'b00))
      r_last_grant <= w_grant[1];
  end

  // Kill during an outstanding fetch marks its response for discard; a kill
  // coinciding with the response is handled combinationally instead.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_discard <= 1'b0;
    else if (r_state == BUSY_I) begin
      if (mem_resp_i)
        r_discard <= 1'b0;
      else if (imem_kill_i)
        r_discard <= 1'b1;
    end
  end

  assign mem_valid_o = ~w_idle;
  assign mem_addr_o  = {r_req.addr[ADDRW-1:2], 2'b00};
  assign mem_we_o    = r_req.we;
  assign mem_wmask_o = r_req.wmask;
  assign mem_wdata_o = r_req.wdata;

  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;
  assign imem_resp_o  = (r_state == BUSY_I) & mem_resp_i & ~r_discard & ~imem_kill_i;
  assign dmem_resp_o  = (r_state == BUSY_D) & mem_resp_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  import orion_types::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [ADDRW-1:0] imem_addr_i;
  logic             imem_valid_i;
  logic             imem_kill_i;
  logic [DATAW-1:0] imem_rdata_o;
  logic             imem_resp_o;
  logic [ADDRW-1:0] dmem_addr_i;
  logic             dmem_valid_i;
  logic             dmem_we_i;
  logic [MASKW-1:0] dmem_wmask_i;
  logic [DATAW-1:0] dmem_wdata_i;
  logic [DATAW-1:0] dmem_rdata_o;
  logic             dmem_resp_o;
  logic [ADDRW-1:0] mem_addr_o;
  logic             mem_valid_o;
  logic             mem_we_o;
  logic [MASKW-1:0] mem_wmask_o;
  logic [DATAW-1:0] mem_wdata_o;
  logic [DATAW-1:0] mem_rdata_i;
  logic             mem_resp_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_addr_i  (imem_addr_i),
    .imem_valid_i (imem_valid_i),
    .imem_kill_i  (imem_kill_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_resp_o  (imem_resp_o),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_valid_i (dmem_valid_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_wmask_i (dmem_wmask_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_resp_o  (dmem_resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_valid_o  (mem_valid_o),
    .mem_we_o     (mem_we_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    imem_addr_i  = '0;
    imem_valid_i = 1'b0;
    imem_kill_i  = 1'b0;
    dmem_addr_i  = '0;
    dmem_valid_i = 1'b0;
    dmem_we_i    = 1'b0;
    dmem_wmask_i = '0;
    dmem_wdata_i = '0;
    mem_rdata_i  = '0;
    mem_resp_i   = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (mem_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", mem_valid_o); end
    n_checks++;
    if (mem_addr_o !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr_o); end
    n_checks++;
    if ({mem_we_o, mem_wmask_o, mem_wdata_o} !== 37'h0) begin
      n_errors++; $display("FAIL reset_wfields: got we=%b mask=%h data=%h expected zeros", mem_we_o, mem_wmask_o, mem_wdata_o);
    end
    n_checks++;
    if ({imem_resp_o, dmem_resp_o} !== 2'b00) begin n_errors++; $display("FAIL reset_resp: got %b expected 00", {imem_resp_o, dmem_resp_o}); end
  endtask

  task automatic test_single_fetch();
    imem_addr_i  = 32'h8000_0003;
    imem_valid_i = 1'b1;
    step();  // granted at the rising edge inside this step
    n_checks++;
    if (mem_valid_o !== 1'b1) begin n_errors++; $display("FAIL fetch_valid: got %b expected 1", mem_valid_o); end
    n_checks++;
    if (mem_addr_o !== 32'h8000_0000) begin n_errors++; $display("FAIL fetch_addr: got %h expected 80000000", mem_addr_o); end
    n_checks++;
    if ({mem_we_o, mem_wmask_o} !== 5'b0) begin n_errors++; $display("FAIL fetch_we: got we=%b mask=%h expected 0/0", mem_we_o, mem_wmask_o); end
    n_checks++;
    if (imem_resp_o !== 1'b0) begin n_errors++; $display("FAIL fetch_early_resp: got %b expected 0", imem_resp_o); end
    mem_rdata_i = 32'h0000_0013;
    mem_resp_i  = 1'b1;
    #1;
    n_checks++;
    if (imem_resp_o !== 1'b1 || imem_rdata_o !== 32'h0000_0013) begin
      n_errors++; $display("FAIL fetch_resp: got resp=%b data=%h expected 1/00000013", imem_resp_o, imem_rdata_o);
    end
    n_checks++;
    if (dmem_resp_o !== 1'b0) begin n_errors++; $display("FAIL fetch_dresp: got %b expected 0", dmem_resp_o); end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (mem_valid_o !== 1'b0) begin n_errors++; $display("FAIL fetch_idle: got %b expected 0", mem_valid_o); end
  endtask

  task automatic test_store();
    dmem_addr_i  = 32'h0000_0100;
    dmem_valid_i = 1'b1;
    dmem_we_i    = 1'b1;
    dmem_wmask_i = 4'b0011;
    dmem_wdata_i = 32'hDEAD_BEEF;
    step();
    n_checks++;
    if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b1 ||
        mem_wmask_o !== 4'b0011 || mem_wdata_o !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL store_fields: got v=%b a=%h we=%b m=%h d=%h expected 1/00000100/1/3/deadbeef",
               mem_valid_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o);
    end
    mem_rdata_i = 32'h1234_5678;
    mem_resp_i  = 1'b1;
    #1;
    n_checks++;
    if (dmem_resp_o !== 1'b1 || dmem_rdata_o !== 32'h1234_5678) begin
      n_errors++; $display("FAIL store_resp: got resp=%b data=%h expected 1/12345678", dmem_resp_o, dmem_rdata_o);
    end
    n_checks++;
    if (imem_resp_o !== 1'b0) begin n_errors++; $display("FAIL store_iresp: got %b expected 0", imem_resp_o); end
    step();
    clear_inputs();
    #1;
  endtask

  task automatic test_tie();
    logic [3:0] exp_d;  // bit k: transaction k should go to dmem
`ifdef ORION_ARB_ROUND_ROBIN_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    apply_reset();
    imem_addr_i  = 32'h0000_1000;
    imem_valid_i = 1'b1;
    dmem_addr_i  = 32'h0000_2000;
    dmem_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (mem_valid_o !== 1'b1 || mem_addr_o !== (exp_d[k] ? 32'h2000 : 32'h1000)) begin
        n_errors++; $display("FAIL tie_grant%0d: got v=%b addr=%h expected 1/%h", k, mem_valid_o, mem_addr_o,
                             exp_d[k] ? 32'h2000 : 32'h1000);
      end
      mem_resp_i = 1'b1;
      #1;
      n_checks++;
      if ({dmem_resp_o, imem_resp_o} !== (exp_d[k] ? 2'b10 : 2'b01)) begin
        n_errors++; $display("FAIL tie_resp%0d: got d/i=%b expected %b", k, {dmem_resp_o, imem_resp_o},
                             exp_d[k] ? 2'b10 : 2'b01);
      end
      step();
      mem_resp_i = 1'b0;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_kill();
    apply_reset();
    // Fetch with kill in IDLE is not granted.
    imem_addr_i  = 32'h0000_0040;
    imem_valid_i = 1'b1;
    imem_kill_i  = 1'b1;
    step();
    n_checks++;
    if (mem_valid_o !== 1'b0) begin n_errors++; $display("FAIL kill_idle_grant: got %b expected 0", mem_valid_o); end
    // Kill one cycle before the response.
    imem_kill_i = 1'b0;
    step();
    imem_valid_i = 1'b0;
    imem_kill_i  = 1'b1;
    step();
    imem_kill_i = 1'b0;
    mem_rdata_i = 32'hAAAA_0001;
    mem_resp_i  = 1'b1;
    #1;
    n_checks++;
    if (imem_resp_o !== 1'b0 || mem_valid_o !== 1'b1) begin
      n_errors++; $display("FAIL kill_early: got resp=%b valid=%b expected 0/1", imem_resp_o, mem_valid_o);
    end
    step();
    mem_resp_i = 1'b0;
    #1;
    n_checks++;
    if (mem_valid_o !== 1'b0) begin n_errors++; $display("FAIL kill_early_idle: got %b expected 0", mem_valid_o); end
    // Kill in the same cycle as the response.
    imem_addr_i  = 32'h0000_0080;
    imem_valid_i = 1'b1;
    step();
    imem_valid_i = 1'b0;
    imem_kill_i  = 1'b1;
    mem_rdata_i  = 32'hAAAA_0002;
    mem_resp_i   = 1'b1;
    #1;
    n_checks++;
    if (imem_resp_o !== 1'b0) begin n_errors++; $display("FAIL kill_same: got %b expected 0", imem_resp_o); end
    step();
    imem_kill_i = 1'b0;
    mem_resp_i  = 1'b0;
    #1;
    n_checks++;
    if (mem_valid_o !== 1'b0) begin n_errors++; $display("FAIL kill_same_idle: got %b expected 0", mem_valid_o); end
    // Next fetch responds normally.
    imem_addr_i  = 32'h0000_00C4;
    imem_valid_i = 1'b1;
    step();
    n_checks++;
    if (mem_addr_o !== 32'h0000_00C4) begin n_errors++; $display("FAIL kill_next_addr: got %h expected 000000c4", mem_addr_o); end
    mem_rdata_i = 32'h0000_0093;
    mem_resp_i  = 1'b1;
    #1;
    n_checks++;
    if (imem_resp_o !== 1'b1 || imem_rdata_o !== 32'h0000_0093) begin
      n_errors++; $display("FAIL kill_next_resp: got resp=%b data=%h expected 1/00000093", imem_resp_o, imem_rdata_o);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    dmem_addr_i  = 32'h0000_0200;
    dmem_valid_i = 1'b1;
    step();
    n_checks++;
    if (mem_valid_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy: got %b expected 1", mem_valid_o); end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (mem_valid_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_errors++; $display("FAIL rstmid_async: got valid=%b addr=%h expected 0/00000000", mem_valid_o, mem_addr_o);
    end
    step();
    clear_inputs();
    rst_i = 1'b0;
    step();
    mem_resp_i = 1'b1;
    #1;
    n_checks++;
    if ({imem_resp_o, dmem_resp_o} !== 2'b00) begin
      n_errors++; $display("FAIL rstmid_stray: got i/d=%b expected 00", {imem_resp_o, dmem_resp_o});
    end
    step();
    mem_resp_i = 1'b0;
  endtask

  task automatic test_stale();
    mem_resp_i  = 1'b1;
    mem_rdata_i = 32'h5555_5555;
    #1;
    n_checks++;
    if ({imem_resp_o, dmem_resp_o} !== 2'b00) begin
      n_errors++; $display("FAIL stale_resp: got i/d=%b expected 00", {imem_resp_o, dmem_resp_o});
    end
    step();
    mem_resp_i = 1'b0;
    #1;
    n_checks++;
    if (mem_valid_o !== 1'b0) begin n_errors++; $display("FAIL stale_state: got %b expected 0", mem_valid_o); end
    // Arbiter still serves a request afterwards.
    dmem_addr_i  = 32'h0000_0304;
    dmem_valid_i = 1'b1;
    step();
    n_checks++;
    if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_0304) begin
      n_errors++; $display("FAIL stale_after: got valid=%b addr=%h expected 1/00000304", mem_valid_o, mem_addr_o);
    end
    mem_resp_i = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_kill();
    test_reset_mid();
    test_stale();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
